rx_line_sequencer: RTL and testbench
====================================

# rx_line_sequencer

Receive-side scan-line sequencer for the 8-channel beamforming adder. On each transmit firing it waits a programmable receive dead time, drives the adder clock-enable for exactly one line of samples, drains the adder pipeline, and tags the adder output stream with sample-valid, start-of-line and end-of-line markers. It sits between the transmit/trigger logic and the line buffer, and is the only block that drives the adder's `ce`.

## Interface
- `ADDER_LAT`, 4: adder pipeline depth, counted in `ce` pulses from input capture to valid `dout`; minimum 2.
- `CNT_W`, 16: width of the sample, delay and line counters.
- `LINE_W`, 10: width of the line index.
- `DECIM_W`, 4: width of the decimation factor; used only when `RX_DECIM_EN` is defined.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: transmit-fired pulse; starts one line.
- `abort` in 1: synchronous abort of the frame.
- `cfg_rx_dly` in CNT_W: number of cycles from `start` to the first sample.
- `cfg_num_samp` in CNT_W: samples per line; must be at least 1.
- `cfg_num_lines` in LINE_W: lines per frame; must be at least 1.
- `cfg_decim` in DECIM_W: cycles between samples, with 0 treated as 1 (`RX_DECIM_EN` only).
- `adder_dout` in 16: adder output.
- `adder_ce` out 1: clock enable to the adder.
- `out_data` out 16: registered copy of `adder_dout`.
- `out_valid` out 1: `out_data` is a line sample.
- `out_sol` out 1: first sample of the line, coincident with `out_valid`.
- `out_eol` out 1: last sample of the line, coincident with `out_valid`.
- `line_idx` out LINE_W: index of the current line.
- `line_done` out 1: one-cycle pulse at line end.
- `frame_done` out 1: one-cycle pulse after the last line.
- `busy` out 1: high in any state other than IDLE and WAIT_TRIG.

## Operation
- The FSM has six states: IDLE, RXDLY, ACQ, FLUSH, DONE and WAIT_TRIG.
- **IDLE.** `start` latches `cfg_*` into shadow registers, clears `line_idx` and moves to RXDLY.
- **RXDLY.** A down-counter runs from the latched `cfg_rx_dly`; when it reaches 0 the FSM moves to ACQ. A value of 0 goes to ACQ on the next cycle.
- **ACQ.** `adder_ce` pulses once per sample period, which is 1 cycle, or `cfg_decim` cycles with decimation. Each pulse pushes a tag {valid, sol, eol} into an ADDER_LAT-deep tag shift register. The tag register shifts only on `adder_ce` pulses. After `cfg_num_samp` pulses the FSM moves to FLUSH.
- **FLUSH.** `adder_ce` pulses at the same rate ADDER_LAT−1 more times, pushing empty tags.
- **DONE, one cycle.** Pulses `line_done`.
  - If `line_idx` equals `cfg_num_lines`−1: pulse `frame_done` in the same cycle and go to IDLE.
  - Otherwise: increment `line_idx` and go to WAIT_TRIG.
- **WAIT_TRIG.** `start` goes to RXDLY. The configuration is not re-latched.
- **Output stage.** Registered:
  - `out_valid` equals `adder_ce` delayed one cycle, ANDed with the valid bit of the tag stage that has reached depth ADDER_LAT.
  - `out_sol` and `out_eol` are taken from the same tag stage.
  - `out_data` captures `adder_dout` on every cycle.
- **Ignored starts.** `start` is ignored in RXDLY, ACQ, FLUSH and DONE. It raises no error.
- **Abort.** `abort` in any state goes to IDLE on the next edge. It forces `adder_ce` to 0, clears all tags, suppresses any pending `out_valid` and `line_done`, and resets `line_idx` to 0. When `abort` and `start` arrive in the same cycle, `abort` wins.
- **Single-sample line.** When `cfg_num_samp` is 1, `out_sol` and `out_eol` are asserted on the same sample.

## Timing
- **Reset values.** `adder_ce`, `out_valid`, `out_sol`, `out_eol`, `line_done`, `frame_done` and `busy` are 0. `out_data` and `line_idx` are 0. The FSM is in IDLE.
- **Start to first sample.** With `start` at cycle t, the first `adder_ce` is at cycle t+1+`cfg_rx_dly`.
- **Sample latency.** A sample captured on an `adder_ce` at cycle s gives `out_valid` in the cycle after that sample's ADDER_LAT-th pulse. The sample's own pulse counts as the first. With no decimation this is s+ADDER_LAT.
- **Line length.** With no decimation a line occupies `cfg_num_samp`+ADDER_LAT−1 cycles of `adder_ce` high.
- **Line end.** `line_done` occurs one cycle after the last `out_valid`.
- **Throughput.** The block is never stalled. The downstream consumer must accept every `out_valid`; there is no backpressure.

## Configuration
- The macro is `RX_DECIM_EN`.
- **Defined.** The `cfg_decim` port and a decimation counter are present. `adder_ce` pulses every `cfg_decim` cycles in ACQ and FLUSH.
- **Undefined.** There is no `cfg_decim` port and `adder_ce` is held high continuously through ACQ and FLUSH.

## Structure
- The shared package `rx_bf_pkg` holds:
  - the state enum;
  - the tag struct {valid, sol, eol};
  - the default constants `ADDER_LAT_DEF`=4 and the 16-bit beamformed sample width.
- Sub-module `rx_tag_pipe` implements the ADDER_LAT-deep, ce-gated tag shift register and drives `out_valid`, `out_sol` and `out_eol`.

## Test plan
- **Basic line.** `cfg_rx_dly`=5, `cfg_num_samp`=8, 1 line, `start` at t=10 → `adder_ce` high for cycles 16–26. `out_valid` during 20–27, with `out_sol`@20 and `out_eol`@27. `line_done` and `frame_done` @28, then IDLE.
- **Multi-line frame.** `cfg_num_lines`=3 with a `start` each line → `line_idx` reads 0, 1, 2. `frame_done` only after the third line. A `start` during ACQ is ignored.
- **Abort mid-line.** `abort` at the 4th ACQ sample → `adder_ce` is 0 the next cycle. No further `out_valid`. No `line_done`. `line_idx`=0 and the FSM is in IDLE.
- **Edge values.** `cfg_num_samp`=1 and `cfg_rx_dly`=0 → `adder_ce` at t+1. A single `out_valid` with both `out_sol` and `out_eol` at t+1+ADDER_LAT.
- **Decimation (`RX_DECIM_EN`).** `cfg_decim`=3, `cfg_num_samp`=4 → `adder_ce` pulses 3 cycles apart, 7 pulses in total. 4 `out_valid` pulses spaced 3 cycles apart.
- **Reset mid-ACQ.** `rst_n` low → all outputs are 0 immediately. After release the FSM is in IDLE and a new `start` runs a clean line.

Source files
------------

// File: rtl/rx_bf_pkg.sv
// Shared types for the receive beamformer sequencing path: FSM states, sample tags, defaults.
// Pure declarations; no latency or flow control of its own.
package rx_bf_pkg;

    localparam int ADDER_LAT_DEF = 4;
    localparam int BF_SAMP_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        RXDLY,
        ACQ,
        FLUSH,
        DONE,
        WAIT_TRIG
    } seq_state_t;

    typedef struct packed {
        logic valid;
        logic sol;
        logic eol;
    } tag_t;

endpackage

// File: rtl/rx_tag_pipe.sv
// ce-gated tag shift register aligning {valid,sol,eol} with adder output; ADDER_LAT ce pulses
// from push to out_valid (output register counts as the last stage); no backpressure, abort clears.
module rx_tag_pipe
    import rx_bf_pkg::*;
#(
    parameter int ADDER_LAT = ADDER_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    input  logic ce,
    input  tag_t tag_in,
    output logic out_valid,
    output logic out_sol,
    output logic out_eol
);

    tag_t sr [ADDER_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADDER_LAT - 1; i++) sr[i] <= '0;
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (abort) begin
            for (int i = 0; i < ADDER_LAT - 1; i++) sr[i] <= '0;
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            // The pulse that moves a tag out of the last shift stage is its ADDER_LAT-th one.
            out_valid <= ce & sr[ADDER_LAT-2].valid;
            out_sol   <= ce & sr[ADDER_LAT-2].valid & sr[ADDER_LAT-2].sol;
            out_eol   <= ce & sr[ADDER_LAT-2].valid & sr[ADDER_LAT-2].eol;
            if (ce) begin
                sr[0] <= tag_in;
                for (int i = 1; i < ADDER_LAT - 1; i++) sr[i] <= sr[i-1];
            end
        end
    end

endmodule

// File: rtl/rx_line_sequencer.sv
// Scan-line sequencer driving adder ce: start -> first ce after 1+cfg_rx_dly cycles, out_valid ADDER_LAT
// ce pulses later; never stalls, no backpressure. Optional decimation with RX_DECIM_EN.
module rx_line_sequencer
    import rx_bf_pkg::*;
#(
    parameter int ADDER_LAT = ADDER_LAT_DEF,
    parameter int CNT_W     = 16,
    parameter int LINE_W    = 10
`ifdef RX_DECIM_EN
   ,parameter int DECIM_W   = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     cfg_rx_dly,
    input  logic [CNT_W-1:0]     cfg_num_samp,
    input  logic [LINE_W-1:0]    cfg_num_lines,
`ifdef RX_DECIM_EN
    input  logic [DECIM_W-1:0]   cfg_decim,
`endif
    input  logic [BF_SAMP_W-1:0] adder_dout,
    output logic                 adder_ce,
    output logic [BF_SAMP_W-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_sol,
    output logic                 out_eol,
    output logic [LINE_W-1:0]    line_idx,
    output logic                 line_done,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int              FC_W    = $clog2(ADDER_LAT) + 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(ADDER_LAT - 1);

    seq_state_t         state;
    logic [CNT_W-1:0]   cnt, scnt;
    logic [FC_W-1:0]    fcnt;
    logic [CNT_W-1:0]   sh_dly, sh_samp;
    logic [LINE_W-1:0]  sh_lines;
    tag_t               tag_q;
    logic [CNT_W-1:0]   dly_src, samp_src;
    logic               acq_go, pace_ok;

`ifdef RX_DECIM_EN
    logic [DECIM_W-1:0] sh_decim, dcnt, dec_src;

    function automatic logic [DECIM_W-1:0] dec_reload(input logic [DECIM_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    assign dec_src = (state == IDLE) ? cfg_decim : sh_decim;
    assign pace_ok = (dcnt == '0);
`else
    assign pace_ok = 1'b1;
`endif

    // A start from IDLE uses the live config because the shadow copy lands on the same edge.
    assign dly_src  = (state == IDLE) ? cfg_rx_dly   : sh_dly;
    assign samp_src = (state == IDLE) ? cfg_num_samp : sh_samp;
    assign acq_go   = ((state == IDLE || state == WAIT_TRIG) && start && dly_src == '0)
                    || (state == RXDLY && cnt == CNT_W'(1));
    assign busy     = (state != IDLE) && (state != WAIT_TRIG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            scnt       <= '0;
            fcnt       <= '0;
            sh_dly     <= '0;
            sh_samp    <= '0;
            sh_lines   <= '0;
            tag_q      <= '0;
            adder_ce   <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            line_idx   <= '0;
`ifdef RX_DECIM_EN
            sh_decim   <= '0;
            dcnt       <= '0;
`endif
        end else begin
            adder_ce   <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            tag_q      <= '0;
            if (abort) begin
                state    <= IDLE;
                line_idx <= '0;
            end else begin
                case (state)
                    IDLE, WAIT_TRIG: begin
                        if (start) begin
                            if (state == IDLE) begin
                                sh_dly   <= cfg_rx_dly;
                                sh_samp  <= cfg_num_samp;
                                sh_lines <= cfg_num_lines;
                                line_idx <= '0;
`ifdef RX_DECIM_EN
                                sh_decim <= cfg_decim;
`endif
                            end
                            if (dly_src != '0) begin
                                state <= RXDLY;
                                cnt   <= dly_src;
                            end
                        end
                    end
                    RXDLY: cnt <= cnt - 1'b1;
                    ACQ: begin
                        if (pace_ok) begin
                            adder_ce <= 1'b1;
                            if (scnt == sh_samp) begin
                                state <= FLUSH;
                                fcnt  <= FC_W'(1);
                            end else begin
                                tag_q <= '{valid: 1'b1, sol: 1'b0,
                                           eol: ((scnt + 1'b1) == sh_samp)};
                                scnt  <= scnt + 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        // After the final flush pulse wait one idle cycle so line_done trails the last out_valid.
                        if (fcnt == FC_LAST) begin
                            if (!adder_ce) begin
                                state      <= DONE;
                                line_done  <= 1'b1;
                                frame_done <= (line_idx == sh_lines - 1'b1);
                            end
                        end else if (pace_ok) begin
                            adder_ce <= 1'b1;
                            fcnt     <= fcnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (frame_done) begin
                            state <= IDLE;
                        end else begin
                            line_idx <= line_idx + 1'b1;
                            state    <= WAIT_TRIG;
                        end
                    end
                    default: state <= IDLE;
                endcase
`ifdef RX_DECIM_EN
                if (state == ACQ || state == FLUSH)
                    dcnt <= pace_ok ? dec_reload(sh_decim) : dcnt - 1'b1;
`endif
                if (acq_go) begin
                    state    <= ACQ;
                    adder_ce <= 1'b1;
                    tag_q    <= '{valid: 1'b1, sol: 1'b1, eol: (samp_src == CNT_W'(1))};
                    scnt     <= CNT_W'(1);
`ifdef RX_DECIM_EN
                    dcnt     <= dec_reload(dec_src);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_data <= '0;
        else        out_data <= adder_dout;
    end

    rx_tag_pipe #(
        .ADDER_LAT (ADDER_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .ce        (adder_ce),
        .tag_in    (tag_q),
        .out_valid (out_valid),
        .out_sol   (out_sol),
        .out_eol   (out_eol)
    );

endmodule

// File: tb/tb_rx_line_sequencer.sv
// Directed bench for rx_line_sequencer: per-cycle output logs checked against hand-computed cycle numbers.
module tb_rx_line_sequencer;

    localparam int NLOG = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_rx_dly = '0;
    logic [15:0] cfg_num_samp = 16'd1;
    logic [9:0]  cfg_num_lines = 10'd1;
`ifdef RX_DECIM_EN
    logic [3:0]  cfg_decim = '0;
`endif
    logic [15:0] adder_dout = '0;
    logic        adder_ce, out_valid, out_sol, out_eol, line_done, frame_done, busy;
    logic [15:0] out_data;
    logic [9:0]  line_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;

    logic [NLOG-1:0] ce_l, v_l, sol_l, eol_l, ld_l, fd_l, busy_l;
    logic [9:0]      li_l [NLOG];

    rx_line_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_rx_dly    (cfg_rx_dly),
        .cfg_num_samp  (cfg_num_samp),
        .cfg_num_lines (cfg_num_lines),
`ifdef RX_DECIM_EN
        .cfg_decim     (cfg_decim),
`endif
        .adder_dout    (adder_dout),
        .adder_ce      (adder_ce),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sol       (out_sol),
        .out_eol       (out_eol),
        .line_idx      (line_idx),
        .line_done     (line_done),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int r;
        r = cyc - base;
        if (r >= 0 && r < NLOG) begin
            ce_l[r]   = adder_ce;
            v_l[r]    = out_valid;
            sol_l[r]  = out_sol;
            eol_l[r]  = out_eol;
            ld_l[r]   = line_done;
            fd_l[r]   = frame_done;
            busy_l[r] = busy;
            li_l[r]   = line_idx;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        adder_dout = 16'(16'hA000 + cyc);
    endtask

    task automatic tick_to(input int n);
        while (cyc - base < n) tick();
    endtask

    task automatic pulse_start_at(input int n);
        tick_to(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mark();
        base   = cyc;
        ce_l   = '0;
        v_l    = '0;
        sol_l  = '0;
        eol_l  = '0;
        ld_l   = '0;
        fd_l   = '0;
        busy_l = '0;
        for (int i = 0; i < NLOG; i++) li_l[i] = '0;
    endtask

    function automatic int first_set(input logic [NLOG-1:0] v);
        for (int i = 0; i < NLOG; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last_set(input logic [NLOG-1:0] v);
        for (int i = NLOG - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        repeat (3) tick();
        check("rst_ce", adder_ce, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sol", out_sol, 0);
        check("rst_eol", out_eol, 0);
        check("rst_line_done", line_done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_line_idx", line_idx, 0);
        rst_n = 1'b1;
        tick();

        // basic line: dly 5, 8 samples, start at 10
        cfg_rx_dly = 16'd5; cfg_num_samp = 16'd8; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(10);
        tick_to(40);
        check("basic_ce_first", first_set(ce_l), 16);
        check("basic_ce_last", last_set(ce_l), 26);
        check("basic_ce_count", $countones(ce_l), 11);
        check("basic_v_first", first_set(v_l), 20);
        check("basic_v_last", last_set(v_l), 27);
        check("basic_v_count", $countones(v_l), 8);
        check("basic_sol_at", first_set(sol_l), 20);
        check("basic_sol_count", $countones(sol_l), 1);
        check("basic_eol_at", first_set(eol_l), 27);
        check("basic_eol_count", $countones(eol_l), 1);
        check("basic_ld_at", first_set(ld_l), 28);
        check("basic_ld_count", $countones(ld_l), 1);
        check("basic_fd_at", first_set(fd_l), 28);
        check("basic_busy_mid", busy_l[12], 1);
        check("basic_busy_end", busy_l[35], 0);
        check("basic_out_data", out_data, 16'(16'hA000 + cyc - 1));

        // three-line frame, extra start during the first ACQ
        cfg_rx_dly = 16'd2; cfg_num_samp = 16'd4; cfg_num_lines = 10'd3;
        mark();
        pulse_start_at(5);
        pulse_start_at(9);
        pulse_start_at(25);
        pulse_start_at(45);
        tick_to(65);
        check("multi_ce_first", first_set(ce_l), 8);
        check("multi_ce_last", last_set(ce_l), 54);
        check("multi_ce_count", $countones(ce_l), 21);
        check("multi_v_first", first_set(v_l), 12);
        check("multi_v_count", $countones(v_l), 12);
        check("multi_ld_first", first_set(ld_l), 16);
        check("multi_ld_count", $countones(ld_l), 3);
        check("multi_fd_count", $countones(fd_l), 1);
        check("multi_fd_at", first_set(fd_l), 56);
        check("multi_idx_l0", li_l[10], 0);
        check("multi_idx_l1", li_l[30], 1);
        check("multi_idx_l2", li_l[50], 2);

        // abort on the 4th ACQ sample of a 2-line frame
        cfg_rx_dly = 16'd3; cfg_num_samp = 16'd8; cfg_num_lines = 10'd2;
        mark();
        pulse_start_at(5);
        tick_to(12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick_to(30);
        check("abort_ce_count", $countones(ce_l), 4);
        check("abort_ce_last", last_set(ce_l), 12);
        check("abort_v_count", $countones(v_l), 0);
        check("abort_ld_count", $countones(ld_l), 0);
        check("abort_line_idx", line_idx, 0);
        check("abort_busy", busy, 0);
        // IDLE re-latches config; WAIT_TRIG would keep the 2-line frame and dly 3
        cfg_rx_dly = 16'd1; cfg_num_samp = 16'd1; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(3);
        tick_to(15);
        check("abort_relatch_ce_first", first_set(ce_l), 5);
        check("abort_relatch_ce_count", $countones(ce_l), 4);
        check("abort_relatch_fd_at", first_set(fd_l), 10);

        // single sample, zero receive delay
        cfg_rx_dly = 16'd0; cfg_num_samp = 16'd1; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(5);
        tick_to(20);
        check("edge_ce_first", first_set(ce_l), 6);
        check("edge_ce_count", $countones(ce_l), 4);
        check("edge_v_count", $countones(v_l), 1);
        check("edge_v_at", first_set(v_l), 10);
        check("edge_sol_at", first_set(sol_l), 10);
        check("edge_eol_at", first_set(eol_l), 10);
        check("edge_ld_at", first_set(ld_l), 11);

`ifdef RX_DECIM_EN
        cfg_decim = 4'd3; cfg_rx_dly = 16'd2; cfg_num_samp = 16'd4; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(5);
        tick_to(40);
        check("decim_ce_first", first_set(ce_l), 8);
        check("decim_ce_gap", ce_l[9], 0);
        check("decim_ce_second", ce_l[11], 1);
        check("decim_ce_last", last_set(ce_l), 26);
        check("decim_ce_count", $countones(ce_l), 7);
        check("decim_v_first", first_set(v_l), 18);
        check("decim_v_mid", v_l[21], 1);
        check("decim_v_last", last_set(v_l), 27);
        check("decim_v_count", $countones(v_l), 4);
        check("decim_ld_at", first_set(ld_l), 28);
        cfg_decim = 4'd0;
`endif

        // asynchronous reset in the middle of ACQ
        cfg_rx_dly = 16'd2; cfg_num_samp = 16'd20; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(5);
        tick_to(12);
        check("rstmid_ce_before", adder_ce, 1);
        check("rstmid_v_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_ce", adder_ce, 0);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_line_idx", line_idx, 0);
        tick();
        rst_n = 1'b1;
        tick();
        cfg_rx_dly = 16'd1; cfg_num_samp = 16'd2; cfg_num_lines = 10'd1;
        mark();
        pulse_start_at(3);
        tick_to(20);
        check("rstmid_new_ce_first", first_set(ce_l), 5);
        check("rstmid_new_ce_count", $countones(ce_l), 5);
        check("rstmid_new_v_first", first_set(v_l), 9);
        check("rstmid_new_v_count", $countones(v_l), 2);
        check("rstmid_new_ld_at", first_set(ld_l), 11);
        check("rstmid_new_fd_count", $countones(fd_l), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
